id_issue_queue: RTL and testbench
=================================

# id_issue_queue

Instruction queue and dual-issue scheduler between the instruction-fetch stage and the two-lane decode stage. It accepts up to two fetched instructions per cycle and stores them in program order. Each cycle it picks zero, one or two head entries to present to decode lane 1 and lane 2, enforcing the pairing rules. Exception and branch flushes empty it.

## Interface
- DEPTH, 8, queue entries; power of two, ≥4
- ENTRY_W, 64, bits per lane entry (PC + instruction + predecode); MSB is the `solo` predecode flag
- clk  in  1  clock; every register updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- line1_pre_to_now_valid_i  in  1  fetch slot 1 is valid
- line2_pre_to_now_valid_i  in  1  fetch slot 2 is valid
- pre_to_ibus  in  2*ENTRY_W  {slot2, slot1}
- now_allowin_o  out  1  queue can accept a full fetch pair
- next_allowin_i  in  1  decode stage accepts this cycle
- line1_now_to_next_valid_o  out  1  lane 1 entry is valid
- line2_now_to_next_valid_o  out  1  lane 2 entry is valid
- to_next_obus  out  2*ENTRY_W  {lane2, lane1}
- excep_flush_i  in  1  exception flush
- branch_flush_i  in  1  branch-redirect flush from decode
- count_o  out  clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage is a circular buffer with a head pointer `hd`, a tail pointer `tl` (both clog2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter `cnt`.
- **Push:** `push_n` = number of valid fetch slots when `now_allowin_o`=1, otherwise 0.
  - Both slots valid: slot1 is written at `tl`, slot2 at `tl+1`.
  - Only one slot valid: that slot is written at `tl`, with no gap left behind it.
  - `tl` advances by `push_n`.
- `now_allowin_o` = (DEPTH − `cnt` ≥ 2). It is computed from registered `cnt` only and does not depend on a same-cycle pop.
- **Issue selection** (combinational from registered state):
  - `v1` = (`cnt` ≥ 1).
  - `v2` = (`cnt` ≥ 2) & ~solo(`hd`) & ~solo(`hd+1`).
  - A solo-flagged entry (branch, CSR, barrier, syscall) therefore always issues alone in lane 1.
- **Outputs:**
  - lane1 bus = entry[`hd`] when `v1`, else 0.
  - lane2 bus = entry[`hd+1`] when `v2`, else 0.
  - valid outputs = `v1` / `v2`, each masked by ~(`excep_flush_i` | `branch_flush_i`).
- **Pop:** `pop_n` = `next_allowin_i` ? (`v1` + `v2`) : 0. `hd` advances by `pop_n`.
- `cnt_next` = `cnt` + `push_n` − `pop_n`. Push and pop in the same cycle are both legal.
- **Flush** (either flush input high):
  - next cycle `hd` = `tl` = `cnt` = 0;
  - push and pop in that cycle are discarded;
  - flush has priority over all other events.
- Entry payload registers are not reset; only pointers and the counter are.

## Timing
- Reset values: `cnt`=0, `hd`=`tl`=0, both valid outputs 0, `to_next_obus`=0, `now_allowin_o`=1, `count_o`=0.
- Latency: an instruction pushed in cycle N can issue in cycle N+1 at the earliest. There is no bypass from the fetch input to the outputs.
- An output pair is held stable while `next_allowin_i`=0 and no flush occurs.
- Empty: both valid outputs 0, `pop_n`=0.
- Full or DEPTH−1 occupied: `now_allowin_o`=0 and the fetch stage holds its data.
- `cnt` must never exceed DEPTH or go below 0. Either condition is an assertion failure.
- Wrap-around: `hd+1` and `tl+1` are taken modulo DEPTH, so a pair may straddle index DEPTH−1/0.
- Reset asserted mid-operation: the queue empties immediately (asynchronously). The first push is accepted on the first edge after reset is released.

## Structure
- The shared package holds `ENTRY_W`, the bit position of the `solo` flag, and the lane bus layout macros, matching the existing `IftToNextBusWidth` and `LineIftToNextBusWidth` definitions.
- One sub-module, `issue_pick`: a combinational pairing-rule block. It takes the head two entries plus `cnt` and produces `v1`, `v2` and the lane buses, so the pairing policy can be swapped later.
- The remaining logic (storage, pointers, counter) lives in `id_issue_queue`.

## Test plan
- **Reset and dual issue:** reset, then push two non-solo entries (PCs 0x1C000000 and 0x1C000004) with `next_allowin_i`=1. Next cycle both lanes are valid with PC 0x…00 / 0x…04; the cycle after, `cnt`=0.
- **Solo entry:** push pair {solo@0x…08, plain@0x…0C}. Lane 1 issues 0x…08 alone (`line2_now_to_next_valid_o`=0); the next cycle lane 1 issues 0x…0C.
- **Fill and backpressure:** hold `next_allowin_i`=0 and push 4 pairs (DEPTH=8). `count_o`=8 and `now_allowin_o`=0; the outputs stay at the first pair. Release: drains in 4 cycles.
- **Wrap-around:** cycle pushes and pops until `hd`=7. The pair at index 7/0 issues in order with correct PCs.
- **Flush collision:** with `cnt`=5, assert `branch_flush_i` together with a valid push and `next_allowin_i`=1. Valid outputs are 0 in that cycle; next cycle `cnt`=0, so the pushed pair is dropped.
- **Single-slot fetch:** push with only line2 valid (PC 0x…20). The entry is stored at `tl`; next cycle it issues on lane 1.

Source files
------------

// File: rtl/id_issue_queue_pkg.sv
// id_issue_queue_pkg: entry width, solo-flag position and lane bus layout shared by the issue queue files
package id_issue_queue_pkg;
  localparam int ENTRY_W = 64;
  localparam int SOLO_BIT = ENTRY_W - 1;
  localparam int LineIftToNextBusWidth = ENTRY_W;
  localparam int IftToNextBusWidth = 2 * LineIftToNextBusWidth;
  typedef logic [ENTRY_W-1:0] entry_t;
  function automatic logic is_solo(entry_t e);
    return e[SOLO_BIT];
  endfunction
endpackage

// File: rtl/id_issue_queue_issue_pick.sv
// id_issue_queue_issue_pick: pairing rule; e1/e2 head entries + cnt in, v1/v2 and zero-gated lane1/lane2 out
module id_issue_queue_issue_pick
  import id_issue_queue_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [ENTRY_W-1:0] e1,
  input  logic [ENTRY_W-1:0] e2,
  input  logic [CW-1:0]      cnt,
  output logic               v1,
  output logic               v2,
  output logic [ENTRY_W-1:0] lane1,
  output logic [ENTRY_W-1:0] lane2
);
  always_comb begin
    v1 = cnt != '0;
    v2 = cnt >= CW'(2) && !is_solo(e1) && !is_solo(e2);
    lane1 = v1 ? e1 : '0;
    lane2 = v2 ? e2 : '0;
  end
endmodule

// File: rtl/id_issue_queue.sv
// id_issue_queue: circular fetch-to-decode queue with dual issue; fetch pair in (pre_to_ibus), two lanes out (to_next_obus), flushes, count_o
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         line1_pre_to_now_valid_i,
  input  logic                         line2_pre_to_now_valid_i,
  input  logic [IftToNextBusWidth-1:0] pre_to_ibus,
  output logic                         now_allowin_o,
  input  logic                         next_allowin_i,
  output logic                         line1_now_to_next_valid_o,
  output logic                         line2_now_to_next_valid_o,
  output logic [IftToNextBusWidth-1:0] to_next_obus,
  input  logic                         excep_flush_i,
  input  logic                         branch_flush_i,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] hd, tl, hd1, tl1;
  logic [CW-1:0] cnt;
  logic [1:0] push_n, pop_n;
  logic flush, v1, v2;
  logic [ENTRY_W-1:0] slot1, slot2, lane1, lane2;
  assign slot1 = pre_to_ibus[ENTRY_W-1:0];
  assign slot2 = pre_to_ibus[2*ENTRY_W-1:ENTRY_W];
  assign hd1 = hd + AW'(1);
  assign tl1 = tl + AW'(1);
  assign flush = excep_flush_i | branch_flush_i;
  assign now_allowin_o = cnt <= CW'(DEPTH - 2);
  assign push_n = now_allowin_o ? {1'b0, line1_pre_to_now_valid_i} + {1'b0, line2_pre_to_now_valid_i} : 2'd0;
  assign pop_n = next_allowin_i ? {1'b0, v1} + {1'b0, v2} : 2'd0;
  assign count_o = cnt;
  assign line1_now_to_next_valid_o = v1 & ~flush;
  assign line2_now_to_next_valid_o = v2 & ~flush;
  assign to_next_obus = {lane2, lane1};
  id_issue_queue_issue_pick #(.CW(CW)) u_pick (
    .e1(mem[hd]),
    .e2(mem[hd1]),
    .cnt(cnt),
    .v1(v1),
    .v2(v2),
    .lane1(lane1),
    .lane2(lane2)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hd <= '0;
      tl <= '0;
      cnt <= '0;
    end else if (flush) begin
      hd <= '0;
      tl <= '0;
      cnt <= '0;
    end else begin
      hd <= hd + AW'(pop_n);
      tl <= tl + AW'(push_n);
      cnt <= cnt + CW'(push_n) - CW'(pop_n);
    end
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) mem[tl] <= line1_pre_to_now_valid_i ? slot1 : slot2;
    if (!flush && push_n == 2'd2) mem[tl1] <= slot2;
  end
  assert property (@(posedge clk) disable iff (rst) cnt <= CW'(DEPTH) && CW'(pop_n) <= cnt + CW'(push_n));
endmodule

// File: tb/tb_id_issue_queue.sv
// tb_id_issue_queue: directed table plus randomized queue-model check of id_issue_queue
module tb_id_issue_queue;
  import id_issue_queue_pkg::*;
  logic clk = 0, rst = 1;
  logic l1v = 0, l2v = 0, na = 0, ef = 0, bf = 0;
  logic [127:0] ibus = '0;
  logic allow, ov1, ov2;
  logic [127:0] obus;
  logic [3:0] count;
  logic [63:0] lane1, lane2;
  int checks = 0, errors = 0;
  logic [63:0] q [$];
  localparam logic [31:0] B = 32'h1C000000;
  always #5 clk = ~clk;
  assign lane1 = obus[63:0];
  assign lane2 = obus[127:64];
  id_issue_queue #(.DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .line1_pre_to_now_valid_i(l1v),
    .line2_pre_to_now_valid_i(l2v),
    .pre_to_ibus(ibus),
    .now_allowin_o(allow),
    .next_allowin_i(na),
    .line1_now_to_next_valid_o(ov1),
    .line2_now_to_next_valid_o(ov2),
    .to_next_obus(obus),
    .excep_flush_i(ef),
    .branch_flush_i(bf),
    .count_o(count)
  );
  typedef struct {
    bit l1v, l2v;
    logic [63:0] d1, d2;
    bit na, ef, bf, ev1, ev2;
    logic [31:0] ep1, ep2;
    int ecnt;
    bit eal;
  } vec_t;
  vec_t tbl [$];
  function automatic logic [63:0] ent(bit s, logic [31:0] off);
    return {s, 31'h0, B + off};
  endfunction
  function automatic logic [31:0] pc(logic [31:0] off);
    return B + off;
  endfunction
  function automatic void add(bit a1, bit a2, logic [63:0] d1, logic [63:0] d2, bit n, bit e, bit b,
                              bit v1, bit v2, logic [31:0] p1, logic [31:0] p2, int c, bit al);
    vec_t v;
    v.l1v = a1; v.l2v = a2; v.d1 = d1; v.d2 = d2; v.na = n; v.ef = e; v.bf = b;
    v.ev1 = v1; v.ev2 = v2; v.ep1 = p1; v.ep2 = p2; v.ecnt = c; v.eal = al;
    tbl.push_back(v);
  endfunction
  task automatic drive(bit a1, bit a2, logic [63:0] d1, logic [63:0] d2, bit n, bit e, bit b);
    l1v = a1; l2v = a2; ibus = {d2, d1}; na = n; ef = e; bf = b;
  endtask
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  initial begin
    logic [63:0] d1, d2;
    bit a1, a2, n, e, b, fl, m1, m2, mal;
    int sz;
    add(1,1,ent(0,'h00),ent(0,'h04),1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0,0, 1,1,pc('h00),pc('h04),2,1);
    add(1,1,ent(1,'h08),ent(0,'h0C),1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0,0, 1,0,pc('h08),0,2,1);
    add(0,0,0,0,1,0,0, 1,0,pc('h0C),0,1,1);
    add(0,0,0,0,1,0,0, 0,0,0,0,0,1);
    add(1,1,ent(0,'h10),ent(0,'h14),0,0,0, 0,0,0,0,0,1);
    add(1,1,ent(0,'h18),ent(0,'h1C),0,0,0, 1,1,pc('h10),pc('h14),2,1);
    add(1,1,ent(0,'h20),ent(0,'h24),0,0,0, 1,1,pc('h10),pc('h14),4,1);
    add(1,1,ent(0,'h28),ent(0,'h2C),0,0,0, 1,1,pc('h10),pc('h14),6,1);
    add(1,1,ent(0,'h30),ent(0,'h34),0,0,0, 1,1,pc('h10),pc('h14),8,0);
    add(0,0,0,0,1,0,0, 1,1,pc('h10),pc('h14),8,0);
    add(0,0,0,0,1,0,0, 1,1,pc('h18),pc('h1C),6,1);
    add(0,0,0,0,1,0,0, 1,1,pc('h20),pc('h24),4,1);
    add(0,0,0,0,1,0,0, 1,1,pc('h28),pc('h2C),2,1);
    add(0,0,0,0,1,0,0, 0,0,0,0,0,1);
    add(1,0,ent(0,'h40),ent(0,'h99),1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0,0, 1,0,pc('h40),0,1,1);
    add(0,1,ent(0,'h98),ent(0,'h20),1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0,0, 1,0,pc('h20),0,1,1);
    add(1,0,ent(0,'h48),0,1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0,0, 1,0,pc('h48),0,1,1);
    add(1,1,ent(0,'h50),ent(0,'h54),1,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,1,0,0, 1,1,pc('h50),pc('h54),2,1);
    add(0,0,0,0,1,0,0, 0,0,0,0,0,1);
    add(1,1,ent(0,'h60),ent(0,'h64),0,0,0, 0,0,0,0,0,1);
    add(1,1,ent(0,'h68),ent(0,'h6C),0,0,0, 1,1,pc('h60),pc('h64),2,1);
    add(1,0,ent(0,'h70),0,0,0,0, 1,1,pc('h60),pc('h64),4,1);
    add(1,1,ent(0,'h78),ent(0,'h7C),1,0,1, 0,0,pc('h60),pc('h64),5,1);
    add(0,0,0,0,1,0,0, 0,0,0,0,0,1);
    add(1,1,ent(0,'h80),ent(0,'h84),0,0,0, 0,0,0,0,0,1);
    add(0,0,0,0,0,1,0, 0,0,pc('h80),pc('h84),2,1);
    add(0,0,0,0,1,0,0, 0,0,0,0,0,1);
    #1;
    chk("reset_count", 64'(count), 0);
    chk("reset_allow", 64'(allow), 1);
    chk("reset_v1", 64'(ov1), 0);
    chk("reset_bus", obus[63:0] | obus[127:64], 0);
    @(negedge clk);
    rst = 0;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].l1v, tbl[i].l2v, tbl[i].d1, tbl[i].d2, tbl[i].na, tbl[i].ef, tbl[i].bf);
      #1;
      chk($sformatf("r%0d_v1", i), 64'(ov1), 64'(tbl[i].ev1));
      chk($sformatf("r%0d_v2", i), 64'(ov2), 64'(tbl[i].ev2));
      chk($sformatf("r%0d_pc1", i), 64'(lane1[31:0]), 64'(tbl[i].ep1));
      chk($sformatf("r%0d_pc2", i), 64'(lane2[31:0]), 64'(tbl[i].ep2));
      chk($sformatf("r%0d_count", i), 64'(count), 64'(tbl[i].ecnt));
      chk($sformatf("r%0d_allow", i), 64'(allow), 64'(tbl[i].eal));
    end
    @(negedge clk);
    drive(1,1,ent(0,'h88),ent(0,'h8C),0,0,0);
    @(negedge clk);
    drive(0,0,0,0,0,0,0);
    #2;
    chk("pre_arst_count", 64'(count), 2);
    rst = 1;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_v1", 64'(ov1), 0);
    chk("arst_allow", 64'(allow), 1);
    @(negedge clk);
    rst = 0;
    drive(1,1,ent(0,'h90),ent(0,'h94),0,0,0);
    #1;
    chk("post_arst_count0", 64'(count), 0);
    @(negedge clk);
    drive(0,0,0,0,1,0,0);
    #1;
    chk("post_arst_count", 64'(count), 2);
    chk("post_arst_pc1", 64'(lane1[31:0]), 64'(pc('h90)));
    chk("post_arst_pc2", 64'(lane2[31:0]), 64'(pc('h94)));
    q.delete();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      a1 = 1'($urandom_range(0, 1));
      a2 = 1'($urandom_range(0, 1));
      d1 = {($urandom_range(0, 3) == 0), 31'h0, 32'($urandom())};
      d2 = {($urandom_range(0, 3) == 0), 31'h0, 32'($urandom())};
      n = $urandom_range(0, 9) < 5;
      e = $urandom_range(0, 39) == 0;
      b = $urandom_range(0, 39) == 0;
      if (i == 0) begin
        n = 1;
        e = 1;
      end
      drive(a1, a2, d1, d2, n, e, b);
      #1;
      sz = q.size();
      fl = e | b;
      m1 = sz >= 1;
      m2 = sz >= 2 && !q[0][63] && !q[1][63];
      mal = (8 - sz) >= 2;
      chk("rnd_v1", 64'(ov1), 64'(m1 && !fl));
      chk("rnd_v2", 64'(ov2), 64'(m2 && !fl));
      chk("rnd_lane1", lane1, m1 ? q[0] : 64'h0);
      chk("rnd_lane2", lane2, m2 ? q[1] : 64'h0);
      chk("rnd_count", 64'(count), 64'(sz));
      chk("rnd_allow", 64'(allow), 64'(mal));
      if (fl) q.delete();
      else begin
        if (n) begin
          if (m1) void'(q.pop_front());
          if (m2) void'(q.pop_front());
        end
        if (mal) begin
          if (a1) q.push_back(d1);
          if (a2) q.push_back(d2);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
